// File: rtl/param_aggregator_pkg.sv
// Shared types for the runtime-configurable lane packer: lane/fetch-width types,
// FILL/HOLD state encoding and the count-to-lane-mask helper.
package param_aggregator_pkg;

    localparam int AGG_DATA_WIDTH = 8;
    localparam int AGG_MAX_FETCH  = 4;
    localparam int AGG_FW_BITS    = $clog2(AGG_MAX_FETCH + 1);
    localparam int AGG_LANE_BITS  = (AGG_MAX_FETCH > 1) ? $clog2(AGG_MAX_FETCH) : 1;

    typedef logic [AGG_LANE_BITS-1:0] lane_idx_t;
    typedef logic [AGG_FW_BITS-1:0]   fw_t;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } agg_state_t;

    // Lanes below cnt are valid.
    function automatic logic [AGG_MAX_FETCH-1:0] count_mask(input fw_t cnt);
        logic [AGG_MAX_FETCH-1:0] m;
        for (int i = 0; i < AGG_MAX_FETCH; i++) begin
            m[i] = (fw_t'(i) < cnt);
        end
        return m;
    endfunction

endpackage

// File: rtl/param_aggregator_if.sv
// Sender FIFO, wide receiver, configuration and flush signals of the aggregator.
// The aggregator uses the slave modport; its environment uses master.
interface param_aggregator_if #(
    parameter int DATA_WIDTH      = param_aggregator_pkg::AGG_DATA_WIDTH,
    parameter int MAX_FETCH_WIDTH = param_aggregator_pkg::AGG_MAX_FETCH,
    parameter int FW_BITS         = $clog2(MAX_FETCH_WIDTH + 1)
);
    logic [DATA_WIDTH-1:0]                 sender_data;
    logic                                  sender_empty_n;
    logic                                  sender_deq;
    logic [MAX_FETCH_WIDTH*DATA_WIDTH-1:0] receiver_data;
    logic [MAX_FETCH_WIDTH-1:0]            receiver_mask;
    logic                                  receiver_full_n;
    logic                                  receiver_enq;
    logic                                  cfg_load;
    logic [FW_BITS-1:0]                    cfg_fetch_width;
    logic                                  cfg_err;
    logic                                  flush;
    logic                                  busy;

    modport slave (
        input  sender_data, sender_empty_n, receiver_full_n,
        input  cfg_load, cfg_fetch_width, flush,
        output sender_deq, receiver_data, receiver_mask, receiver_enq,
        output cfg_err, busy
    );

    modport master (
        output sender_data, sender_empty_n, receiver_full_n,
        output cfg_load, cfg_fetch_width, flush,
        input  sender_deq, receiver_data, receiver_mask, receiver_enq,
        input  cfg_err, busy
    );
endinterface

// File: rtl/param_aggregator_agg_out_stage.sv
// One-entry output register for the packed word with a valid/ready handshake.
// A load is only issued while slot_free_o is high, so held data never changes under backpressure.
module agg_out_stage #(
    parameter int WIDTH = 32,
    parameter int LANES = 4
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic [LANES-1:0] load_mask_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic [LANES-1:0] mask_o,
    output logic             valid_o,
    output logic             slot_free_o,
    output logic             enq_o
);
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [LANES-1:0] mask_q, mask_d;

    assign enq_o       = valid_q && ready_i;
    assign slot_free_o = !valid_q || enq_o;
    assign valid_o     = valid_q;
    assign data_o      = data_q;
    assign mask_o      = mask_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        mask_d  = mask_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = load_data_i;
            mask_d  = load_mask_i;
        end else if (enq_o) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            mask_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
        end
    end
endmodule

// File: rtl/param_aggregator.sv
// Packs 1..MAX_FETCH_WIDTH sender words into one wide receiver word, with runtime
// fetch-width changes at word boundaries and a flush that emits a partial word.
//
//   state   | meaning
//   --------+-----------------------------------------------------------------
//   ST_FILL | count < fw_active; accepting sender words, flush/cfg handled here
//   ST_HOLD | count == fw_active; full word waiting for the output slot
module param_aggregator
    import param_aggregator_pkg::*;
#(
    parameter int DATA_WIDTH        = AGG_DATA_WIDTH,
    parameter int MAX_FETCH_WIDTH   = AGG_MAX_FETCH,
    parameter int RESET_FETCH_WIDTH = 2,
    parameter int FW_BITS           = $clog2(MAX_FETCH_WIDTH + 1)
) (
    input  logic              wclk,
    input  logic              wrst_n,
    param_aggregator_if.slave bus
);
    localparam int W = MAX_FETCH_WIDTH * DATA_WIDTH;

    agg_state_t            state_q, state_d;
    logic [FW_BITS-1:0]    count_q, count_d;
    logic [FW_BITS-1:0]    fw_active_q, fw_active_d;
    logic [FW_BITS-1:0]    fw_pend_q, fw_pend_d;
    logic                  pend_valid_q, pend_valid_d;
    logic                  flush_pend_q, flush_pend_d;
    logic                  cfg_err_q, cfg_err_d;
    logic [DATA_WIDTH-1:0] acc_q [MAX_FETCH_WIDTH];
    logic [DATA_WIDTH-1:0] acc_d [MAX_FETCH_WIDTH];

    logic [FW_BITS-1:0]         cnt_inc;
    logic                       last_lane, below_last, cfg_ok;
    logic                       slot_free, out_valid, deq, out_load;
    logic [MAX_FETCH_WIDTH-1:0] load_mask;
    logic [W-1:0]               load_data;

    assign cnt_inc    = count_q + FW_BITS'(1);
    assign last_lane  = (cnt_inc == fw_active_q);
    assign below_last = (cnt_inc < fw_active_q);
    assign cfg_ok     = (bus.cfg_fetch_width != '0) &&
                        (bus.cfg_fetch_width <= FW_BITS'(MAX_FETCH_WIDTH));

    // A pending width change owns the cycle with count==0, which costs one bubble.
    assign deq = wrst_n && bus.sender_empty_n && (state_q == ST_FILL) && !flush_pend_q &&
                 !((count_q == '0) && pend_valid_q) && (below_last || slot_free);

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        fw_active_d  = fw_active_q;
        fw_pend_d    = fw_pend_q;
        pend_valid_d = pend_valid_q;
        flush_pend_d = flush_pend_q;
        cfg_err_d    = 1'b0;
        out_load     = 1'b0;
        load_mask    = '0;
        acc_d        = acc_q;

        case (state_q)
            ST_FILL: begin
                if (deq) begin
                    acc_d[lane_idx_t'(count_q)] = bus.sender_data;
                    if (last_lane) begin
                        if (slot_free) begin
                            out_load  = 1'b1;
                            load_mask = count_mask(fw_active_q);
                            count_d   = '0;
                        end else begin
                            count_d = fw_active_q;
                            state_d = ST_HOLD;
                        end
                    end else begin
                        count_d = cnt_inc;
                    end
                end else if (flush_pend_q) begin
                    if (count_q == '0) begin
                        flush_pend_d = 1'b0;
                    end else if (slot_free) begin
                        out_load     = 1'b1;
                        load_mask    = count_mask(count_q);
                        count_d      = '0;
                        flush_pend_d = 1'b0;
                    end
                end else if (pend_valid_q && (count_q == '0)) begin
                    fw_active_d  = fw_pend_q;
                    pend_valid_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (slot_free) begin
                    out_load  = 1'b1;
                    load_mask = count_mask(fw_active_q);
                    count_d   = '0;
                    state_d   = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase

        if (bus.flush) begin
            flush_pend_d = 1'b1;
        end
        // A new request issued in the same cycle as an apply becomes the next pending value.
        if (bus.cfg_load) begin
            if (cfg_ok) begin
                fw_pend_d    = bus.cfg_fetch_width;
                pend_valid_d = 1'b1;
            end else begin
                cfg_err_d = 1'b1;
            end
        end
    end

    // Lanes outside the mask go out as zero regardless of stale accumulator content.
    always_comb begin
        load_data = '0;
        for (int i = 0; i < MAX_FETCH_WIDTH; i++) begin
            if (load_mask[i]) begin
                load_data[i*DATA_WIDTH +: DATA_WIDTH] = acc_d[i];
            end
        end
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            state_q      <= ST_FILL;
            count_q      <= '0;
            fw_active_q  <= FW_BITS'(RESET_FETCH_WIDTH);
            fw_pend_q    <= '0;
            pend_valid_q <= 1'b0;
            flush_pend_q <= 1'b0;
            cfg_err_q    <= 1'b0;
            for (int i = 0; i < MAX_FETCH_WIDTH; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            fw_active_q  <= fw_active_d;
            fw_pend_q    <= fw_pend_d;
            pend_valid_q <= pend_valid_d;
            flush_pend_q <= flush_pend_d;
            cfg_err_q    <= cfg_err_d;
            acc_q        <= acc_d;
        end
    end

    agg_out_stage #(
        .WIDTH (W),
        .LANES (MAX_FETCH_WIDTH)
    ) u_out_stage (
        .wclk        (wclk),
        .wrst_n      (wrst_n),
        .load_i      (out_load),
        .load_data_i (load_data),
        .load_mask_i (load_mask),
        .ready_i     (bus.receiver_full_n),
        .data_o      (bus.receiver_data),
        .mask_o      (bus.receiver_mask),
        .valid_o     (out_valid),
        .slot_free_o (slot_free),
        .enq_o       (bus.receiver_enq)
    );

    assign bus.sender_deq = deq;
    assign bus.cfg_err    = cfg_err_q;
    assign bus.busy       = (count_q != '0) || out_valid || flush_pend_q || pend_valid_q;
endmodule

// File: tb/tb_param_aggregator.sv
// Scoreboard bench for param_aggregator: expected packed words are queued with the
// stimulus and a negedge monitor pops and compares them on every receiver_enq.
module tb_param_aggregator;
    localparam int DW  = 8;
    localparam int MF  = 4;
    localparam int FWB = 3;

    logic wclk   = 1'b0;
    logic wrst_n = 1'b0;
    always #5 wclk = ~wclk;

    param_aggregator_if #(.DATA_WIDTH(DW), .MAX_FETCH_WIDTH(MF), .FW_BITS(FWB)) bus ();

    param_aggregator #(
        .DATA_WIDTH        (DW),
        .MAX_FETCH_WIDTH   (MF),
        .RESET_FETCH_WIDTH (2),
        .FW_BITS           (FWB)
    ) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus)
    );

    typedef struct packed {
        logic [MF*DW-1:0] data;
        logic [MF-1:0]    mask;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [DW-1:0] src[$];
    int            checks = 0;
    int            errors = 0;
    int            n_ticks;
    logic          deq_seen = 1'b0;
    bit            rand_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic expect_word(input logic [DW-1:0] l0, input logic [DW-1:0] l1,
                               input logic [DW-1:0] l2, input logic [DW-1:0] l3, input int n);
        exp_t          e;
        logic [DW-1:0] l [MF];
        l[0] = l0; l[1] = l1; l[2] = l2; l[3] = l3;
        e.data = '0;
        e.mask = '0;
        for (int i = 0; i < n; i++) begin
            e.data[i*DW +: DW] = l[i];
            e.mask[i]          = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    task automatic drive_src();
        bus.sender_empty_n = (src.size() > 0);
        bus.sender_data    = (src.size() > 0) ? src[0] : '0;
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
        if (deq_seen && src.size() > 0) void'(src.pop_front());
        bus.cfg_load = 1'b0;
        bus.flush    = 1'b0;
        if (rand_ready) bus.receiver_full_n = ($urandom_range(0, 1) != 0);
        drive_src();
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((src.size() > 0 || exp_q.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d words and %0d results outstanding after %0d cycles",
                     name, src.size(), exp_q.size(), n);
        end
        repeat (3) tick();
    endtask

    always @(negedge wclk) begin
        deq_seen = bus.sender_deq;
        if (bus.receiver_enq === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_enq: got data %0h mask %0b, expected no word",
                         bus.receiver_data, bus.receiver_mask);
            end else begin
                mon_e = exp_q.pop_front();
                check("enq_data", bus.receiver_data, mon_e.data);
                check("enq_mask", bus.receiver_mask, mon_e.mask);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sender_data     = '0;
        bus.sender_empty_n  = 1'b0;
        bus.receiver_full_n = 1'b1;
        bus.cfg_load        = 1'b0;
        bus.cfg_fetch_width = '0;
        bus.flush           = 1'b0;

        // reset values
        repeat (3) tick();
        check("rst_enq",  bus.receiver_enq,  0);
        check("rst_data", bus.receiver_data, 0);
        check("rst_mask", bus.receiver_mask, 0);
        check("rst_deq",  bus.sender_deq,    0);
        check("rst_err",  bus.cfg_err,       0);
        check("rst_busy", bus.busy,          0);
        wrst_n = 1'b1;
        tick();

        // fw=2 ramp, receiver always ready
        for (int i = 0; i < 8; i++) src.push_back(8'(i));
        for (int i = 0; i < 8; i += 2) expect_word(8'(i), 8'(i + 1), 8'h00, 8'h00, 2);
        drive_src();
        n_ticks = 0;
        while (src.size() > 0 && n_ticks < 40) begin
            tick();
            n_ticks++;
        end
        check("fw2_deq_cycles", n_ticks, 8);
        drain("fw2", 20);

        // fw=1 with random receiver backpressure
        bus.cfg_fetch_width = 3'd1;
        bus.cfg_load        = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 8; i++) begin
            src.push_back(8'(32 + i));
            expect_word(8'(32 + i), 8'h00, 8'h00, 8'h00, 1);
        end
        drive_src();
        rand_ready = 1'b1;
        drain("fw1_random", 300);
        rand_ready          = 1'b0;
        bus.receiver_full_n = 1'b1;
        tick();

        // back to fw=2, then request fw=4 while count==1
        bus.cfg_fetch_width = 3'd2;
        bus.cfg_load        = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 6; i++) src.push_back(8'(8'h30 + i));
        expect_word(8'h30, 8'h31, 8'h00, 8'h00, 2);
        expect_word(8'h32, 8'h33, 8'h34, 8'h35, 4);
        drive_src();
        tick();
        n_ticks             = 1;
        bus.cfg_fetch_width = 3'd4;
        bus.cfg_load        = 1'b1;
        while (src.size() > 0 && n_ticks < 40) begin
            tick();
            n_ticks++;
        end
        check("cfg_bubble_cycles", n_ticks, 7);
        drain("cfg4", 20);

        // rejected widths
        bus.cfg_fetch_width = 3'd0;
        bus.cfg_load        = 1'b1;
        tick();
        check("cfg_err_zero", bus.cfg_err, 1);
        tick();
        check("cfg_err_zero_clear", bus.cfg_err, 0);
        check("cfg_err_zero_busy", bus.busy, 0);
        bus.cfg_fetch_width = 3'd5;
        bus.cfg_load        = 1'b1;
        tick();
        check("cfg_err_five", bus.cfg_err, 1);
        tick();
        check("cfg_err_five_clear", bus.cfg_err, 0);
        check("cfg_err_five_busy", bus.busy, 0);

        // fw=4 partial word then flush; upper lane must be zero
        src.push_back(8'h0A); src.push_back(8'h0B); src.push_back(8'h0C);
        expect_word(8'h0A, 8'h0B, 8'h0C, 8'h00, 3);
        drive_src();
        n_ticks = 0;
        while (src.size() > 0 && n_ticks < 20) begin
            tick();
            n_ticks++;
        end
        check("partial_deq_cycles", n_ticks, 3);
        repeat (2) tick();
        check("partial_busy", bus.busy, 1);
        check("partial_no_enq", exp_q.size(), 1);
        bus.flush = 1'b1;
        tick();
        drain("flush_partial", 20);
        check("flush_partial_busy", bus.busy, 0);

        // flush with nothing accumulated
        bus.flush = 1'b1;
        tick();
        check("flush_empty_pending", bus.busy, 1);
        tick();
        check("flush_empty_done", bus.busy, 0);
        repeat (4) tick();

        // reset with count 3 discards the partial word
        src.push_back(8'h40); src.push_back(8'h41); src.push_back(8'h42);
        drive_src();
        repeat (3) tick();
        check("pre_reset_busy", bus.busy, 1);
        wrst_n = 1'b0;
        src.push_back(8'h50);
        drive_src();
        #1;
        check("deq_in_reset", bus.sender_deq, 0);
        repeat (2) tick();
        check("mid_rst_busy", bus.busy,          0);
        check("mid_rst_enq",  bus.receiver_enq,  0);
        check("mid_rst_mask", bus.receiver_mask, 0);
        check("mid_rst_data", bus.receiver_data, 0);
        check("mid_rst_src",  src.size(),        1);
        wrst_n = 1'b1;
        src.push_back(8'h51); src.push_back(8'h52); src.push_back(8'h53);
        expect_word(8'h50, 8'h51, 8'h00, 8'h00, 2);
        expect_word(8'h52, 8'h53, 8'h00, 8'h00, 2);
        drive_src();
        drain("after_reset", 30);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/param_aggregator.md
# param_aggregator

Runtime-configurable successor to the fixed-width aggregator. It pops DATA_WIDTH words from a first-word-fall-through sender FIFO and packs 1..MAX_FETCH_WIDTH of them into one wide receiver word. It supports a fetch-width change at word boundaries, a flush that emits a partial word with a lane-valid mask, and a one-entry output stage that sustains one input word per cycle. It sits between the write-side SyncFIFO and the wide consumer in the wclk domain.

## Interface
- DATA_WIDTH, 8, width of one sender word
- MAX_FETCH_WIDTH, 4, maximum lanes per packed word
- RESET_FETCH_WIDTH, 2, active fetch width after reset (1..MAX_FETCH_WIDTH)
- FW_BITS, $clog2(MAX_FETCH_WIDTH+1), width of fetch-width fields
- wclk  in  1  clock
- wrst_n  in  1  reset, synchronous, active-low; clock wclk
- sender_data  in  DATA_WIDTH  head word of sender FIFO
- sender_empty_n  in  1  head word valid
- sender_deq  out  1  pop head word this cycle
- receiver_data  out  MAX_FETCH_WIDTH*DATA_WIDTH  packed word; lane 0 = first word received, at LSBs
- receiver_mask  out  MAX_FETCH_WIDTH  per-lane valid
- receiver_full_n  in  1  receiver can accept
- receiver_enq  out  1  transfer this cycle
- cfg_load  in  1  one-cycle request to change fetch width
- cfg_fetch_width  in  FW_BITS  requested width
- cfg_err  out  1  one-cycle pulse: rejected request
- flush  in  1  one-cycle request to emit a partial word
- busy  out  1  count!=0 or out_valid or a flush/cfg is pending

## Operation
- Registers: acc lanes, count (0..MAX), fw_active, fw_pend + pend_valid, flush_pend, out_data/out_mask/out_valid.
- State: FILL (count<fw_active) or HOLD (count==fw_active; output slot blocked).
- slot_free = !out_valid || receiver_enq.
- receiver_enq = out_valid && receiver_full_n, combinational.
- sender_deq = sender_empty_n && state==FILL && !flush_pend && !(count==0 && pend_valid) && (count<fw_active-1 || slot_free). It is forced 0 while wrst_n is low.
- On a deq, sender_data is written to lane[count] and count increments.
- Completion:
  - A deq with count==fw_active-1 and slot_free loads out_data and out_mask (low fw_active bits set) directly. Count goes to 0.
  - If the slot is not free, the FSM enters HOLD. It transfers on the first slot_free cycle, then returns to FILL with count 0.
- Unused upper lanes of out_data are 0.
- cfg_load:
  - Accepted values are 1..MAX_FETCH_WIDTH. An accepted value is written to fw_pend and sets pend_valid; a later load overwrites a pending one.
  - A value of 0 or >MAX produces a cfg_err pulse the next cycle. The request is ignored.
  - The pending value is applied at the edge of a cycle with count==0 and no flush_pend. sender_deq is 0 in that cycle (one bubble).
- flush:
  - Sets flush_pend; sender_deq is 0 while it is set.
  - If count>0 in FILL: on the first slot_free cycle, acc goes to out with mask = low count bits. Count and flush_pend clear.
  - If count==0: flush_pend clears with no output.
  - In HOLD: the full word is emitted normally, then flush_pend clears with no extra word.
- Simultaneous flush and completing deq on the same edge: the completion wins (full mask), and the flush then finds count==0.

## Timing
- Reset values:
  - Outputs: receiver_enq 0, receiver_data 0, receiver_mask 0, sender_deq 0, cfg_err 0, busy 0.
  - State: count 0, fw_active RESET_FETCH_WIDTH, pend_valid 0, flush_pend 0.
- Reset mid-word discards the partial acc and the pending cfg/flush. No output is produced.
- Latency: the edge of the last lane's deq loads out; receiver_enq can assert the next cycle.
- Throughput: one sender word per cycle while receiver_full_n stays high, for any fw_active, including 1.
- out_data and out_mask stay stable while out_valid && !receiver_full_n.
- flush/cfg_load are sampled on the edge; their effects are visible from the next cycle.

## Structure
- A shared package holds:
  - the lane-index and fetch-width typedefs;
  - the FILL/HOLD state enum;
  - the function that makes a mask from a count.
- Sub-module: agg_out_stage, the one-entry output register with its valid/ready handshake (out_valid, slot_free).

## Test plan
- fw=2, continuous ramp 0,1,2,...; receiver always ready -> receiver_data lanes {1,0},{3,2},... mask 4'b0011, one enq every 2 cycles, sender_deq high every cycle.
- fw=1 with receiver_full_n toggled randomly -> every word out once in order, mask 4'b0001, no loss while HOLD.
- cfg_load 4 mid-word (count 1, fw 2) -> current word completes at width 2, one bubble, next words {3,2,1,0}-style with mask 4'b1111.
- cfg_load 0 and cfg_load 5 -> cfg_err pulses, fw_active unchanged.
- fw=4, three words 10,11,12, then flush -> one enq: lanes 0..2 = 10,11,12, lane3 0, mask 4'b0111; flush with count 0 -> no enq.
- Reset asserted with count 3 -> no enq, busy 0 after reset; the next word starts at lane 0.
